// File: rtl/ec2_microprocessor.sv
// ec2_microprocessor: 8-bit accumulator machine with a 32-word unified program/data RAM.
// The RAM is loaded at reset with a program that computes GCD(X, Y) by repeated
// subtraction. X and Y are entered through the Input/Enter handshake, and the
// result appears on Output while Halt is high.
//
// Ports:
//   Clock      - system clock, rising edge
//   Reset      - synchronous active-high reset (priority over Initialize)
//   Initialize - synchronous active-high restart, same effect as Reset
//   Enter      - operator strobe, Input is valid
//   Input      - operator data for the IN instruction
//   Halt       - high while in the HALT state
//   Q_Meminst  - RAM address bus: PC in FETCH, operand address otherwise
//   Q_ram      - combinational RAM read data at Q_Meminst
//   Q_A        - accumulator
//   Asel       - accumulator source: 00 ALU, 01 Input, 10 RAM, 11 hold
//   Output     - always equals the accumulator
//   state      - FSM state code
//   IR         - opcode register
module ec2_microprocessor #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enter,
  input  logic [DATA_W-1:0] Input,
  input  logic              Initialize,
  output logic              Halt,
  output logic [ADDR_W-1:0] Q_Meminst,
  output logic [DATA_W-1:0] Q_ram,
  output logic [DATA_W-1:0] Q_A,
  output logic [1:0]        Asel,
  output logic [DATA_W-1:0] Output,
  output logic [3:0]        state,
  output logic [2:0]        IR
);

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StHalt   = 4'd7,
    StLoad   = 4'd8,
    StStore  = 4'd9,
    StAdd    = 4'd10,
    StSub    = 4'd11,
    StInput  = 4'd12,
    StInWait = 4'd13,
    StJz     = 4'd14,
    StJpos   = 4'd15
  } state_e;

  localparam int unsigned Words = 2 ** ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] ram_q [Words];

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] ram_rd;
  logic              a_zero;
  logic              a_pos;

  // GCD program image; unlisted words are zero.
  function automatic logic [7:0] rom_word(input int unsigned addr);
    case (addr)
      0:  rom_word = 8'h80;
      1:  rom_word = 8'h3E;
      2:  rom_word = 8'h80;
      3:  rom_word = 8'h3F;
      4:  rom_word = 8'h1E;
      5:  rom_word = 8'h7F;
      6:  rom_word = 8'hAE;
      7:  rom_word = 8'hCC;
      8:  rom_word = 8'h1F;
      9:  rom_word = 8'h7E;
      10: rom_word = 8'h3F;
      11: rom_word = 8'hC4;
      12: rom_word = 8'h3E;
      13: rom_word = 8'hC4;
      14: rom_word = 8'h1E;
      15: rom_word = 8'hE0;
      default: rom_word = 8'h00;
    endcase
  endfunction

  always_comb begin
    mem_addr = (state_q == StFetch) ? pc_q : addr_q;
    ram_rd   = ram_q[mem_addr];
    a_zero   = (a_q == '0);
    a_pos    = !a_q[DATA_W-1] && !a_zero;
  end

  always_ff @(posedge Clock) begin
    if (Reset || Initialize) begin
      state_q <= StStart;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      for (int i = 0; i < Words; i++) begin
        ram_q[i] <= DATA_W'(rom_word(i));
      end
    end else begin
      case (state_q)
        StStart: state_q <= StFetch;
        StFetch: begin
          ir_q    <= ram_rd[DATA_W-1 -: 3];
          addr_q  <= ram_rd[ADDR_W-1:0];
          pc_q    <= pc_q + 1'b1;
          state_q <= StDecode;
        end
        StDecode: begin
          case (ir_q)
            3'b000:  state_q <= StLoad;
            3'b001:  state_q <= StStore;
            3'b010:  state_q <= StAdd;
            3'b011:  state_q <= StSub;
            3'b100:  state_q <= StInput;
            3'b101:  state_q <= StJz;
            3'b110:  state_q <= StJpos;
            default: state_q <= StHalt;
          endcase
        end
        StLoad: begin
          a_q     <= ram_rd;
          state_q <= StFetch;
        end
        StStore: begin
          ram_q[addr_q] <= a_q;
          state_q       <= StFetch;
        end
        StAdd: begin
          a_q     <= a_q + ram_rd;
          state_q <= StFetch;
        end
        StSub: begin
          a_q     <= a_q - ram_rd;
          state_q <= StFetch;
        end
        StInput: begin
          if (Enter) begin
            a_q     <= Input;
            state_q <= StInWait;
          end
        end
        // Wait for Enter to drop so one strobe loads exactly one value.
        StInWait: begin
          if (!Enter) state_q <= StFetch;
        end
        StJz: begin
          if (a_zero) pc_q <= addr_q;
          state_q <= StFetch;
        end
        StJpos: begin
          if (a_pos) pc_q <= addr_q;
          state_q <= StFetch;
        end
        StHalt: begin
          if (Enter) begin
            pc_q    <= '0;
            state_q <= StStart;
          end
        end
        default: state_q <= StStart;
      endcase
    end
  end

  always_comb begin
    Asel = 2'b11;
    case (state_q)
      StLoad:         Asel = 2'b10;
      StAdd, StSub:   Asel = 2'b00;
      StInput:        Asel = Enter ? 2'b01 : 2'b11;
      default:        Asel = 2'b11;
    endcase
  end

  assign Halt      = (state_q == StHalt);
  assign Q_Meminst = mem_addr;
  assign Q_ram     = ram_rd;
  assign Q_A       = a_q;
  assign Output    = a_q;
  assign state     = state_q;
  assign IR        = ir_q;

endmodule

// File: tb/tb_ec2_microprocessor.sv
// Bench for ec2_microprocessor. Stimulus pushes the expected GCD onto a queue;
// a monitor pops and compares each time Halt rises.
module tb_ec2_microprocessor;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Enter = 1'b0;
  logic [7:0] Input = 8'd0;
  logic       Initialize = 1'b0;
  logic       Halt;
  logic [4:0] Q_Meminst;
  logic [7:0] Q_ram;
  logic [7:0] Q_A;
  logic [1:0] Asel;
  logic [7:0] Output;
  logic [3:0] state;
  logic [2:0] IR;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic       halt_prev = 1'b0;

  ec2_microprocessor dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enter      (Enter),
    .Input      (Input),
    .Initialize (Initialize),
    .Halt       (Halt),
    .Q_Meminst  (Q_Meminst),
    .Q_ram      (Q_ram),
    .Q_A        (Q_A),
    .Asel       (Asel),
    .Output     (Output),
    .state      (state),
    .IR         (IR)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each rising Halt consumes one expected result.
  always @(negedge Clock) begin
    if (Halt === 1'b1 && !halt_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_halt", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("gcd_output", {24'd0, Output}, {24'd0, e});
        check("halt_state", {28'd0, state}, 32'd7);
      end
    end
    halt_prev = (Halt === 1'b1);
  end

  task automatic do_reset(input bit use_init);
    if (use_init) Initialize = 1'b1; else Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    Initialize = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] st, input int bound, input string name);
    int n = 0;
    while (state !== st && n < bound) begin
      @(negedge Clock);
      n++;
    end
    if (state !== st) check(name, {28'd0, state}, {28'd0, st});
  endtask

  task automatic enter_value(input logic [7:0] v, input int len);
    wait_state(4'd12, 200, "wait_input");
    Input = v;
    Enter = 1'b1;
    repeat (len) @(negedge Clock);
    Enter = 1'b0;
    @(negedge Clock);
  endtask

  task automatic wait_halt(input int bound);
    int n = 0;
    while (Halt !== 1'b1 && n < bound) begin
      @(negedge Clock);
      n++;
    end
    if (Halt !== 1'b1) check("halt_timeout", 32'd0, 32'd1);
    @(negedge Clock);
  endtask

  initial begin
    @(negedge Clock);
    // Reset state
    do_reset(1'b0);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_halt", {31'd0, Halt}, 32'd0);
    check("rst_a", {24'd0, Q_A}, 32'd0);
    check("rst_ir", {29'd0, IR}, 32'd0);
    check("rst_ram0", {24'd0, Q_ram}, 32'h80);
    check("rst_asel", {30'd0, Asel}, 32'd3);
    @(negedge Clock);
    check("first_fetch_state", {28'd0, state}, 32'd1);
    check("first_fetch_pc", {27'd0, Q_Meminst}, 32'd0);

    // GCD(12, 18) = 6, Enter held 3 cycles
    exp_q.push_back(8'd6);
    enter_value(8'd12, 3);
    enter_value(8'd18, 3);
    wait_halt(2000);

    // Rerun from HALT: GCD(40, 24) = 8; the HALT-exit strobe feeds the first IN
    exp_q.push_back(8'd8);
    Input = 8'd40;
    Enter = 1'b1;
    @(negedge Clock);
    check("rerun_halt_drop", {31'd0, Halt}, 32'd0);
    check("rerun_start", {28'd0, state}, 32'd0);
    repeat (5) @(negedge Clock);
    check("rerun_first_in", {24'd0, Q_A}, 32'd40);
    Enter = 1'b0;
    @(negedge Clock);
    enter_value(8'd24, 2);
    wait_halt(2000);

    // GCD(7, 7) = 7 via Initialize
    do_reset(1'b1);
    check("init_state", {28'd0, state}, 32'd0);
    exp_q.push_back(8'd7);
    enter_value(8'd7, 1);
    enter_value(8'd7, 1);
    wait_halt(2000);

    // GCD(1, 127) = 1, long loop
    do_reset(1'b0);
    exp_q.push_back(8'd1);
    enter_value(8'd1, 2);
    enter_value(8'd127, 2);
    wait_halt(10000);

    // Enter held on X=13 loads once; FSM holds in INWAIT
    do_reset(1'b0);
    exp_q.push_back(8'd1);
    wait_state(4'd12, 200, "wait_input_13");
    Input = 8'd13;
    Enter = 1'b1;
    @(negedge Clock);
    check("inwait_a", {24'd0, Q_A}, 32'd13);
    check("inwait_state", {28'd0, state}, 32'd13);
    Input = 8'd99;
    repeat (2) @(negedge Clock);
    check("inwait_hold_a", {24'd0, Q_A}, 32'd13);
    check("inwait_hold_state", {28'd0, state}, 32'd13);
    Enter = 1'b0;
    @(negedge Clock);
    check("inwait_exit", {28'd0, state}, 32'd1);
    wait_state(4'd12, 200, "wait_second_in");
    repeat (3) @(negedge Clock);
    check("second_in_stall", {28'd0, state}, 32'd12);
    check("second_in_asel", {30'd0, Asel}, 32'd3);
    enter_value(8'd5, 1);
    wait_halt(2000);

    // Reset mid-loop
    do_reset(1'b0);
    enter_value(8'd100, 1);
    enter_value(8'd3, 1);
    repeat (40) @(negedge Clock);
    check("midloop_not_halted", {31'd0, Halt}, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midrst_state", {28'd0, state}, 32'd0);
    check("midrst_a", {24'd0, Q_A}, 32'd0);
    check("midrst_halt", {31'd0, Halt}, 32'd0);
    check("midrst_ram00", {24'd0, Q_ram}, 32'h80);
    check("midrst_ram1e", {24'd0, dut.ram_q[30]}, 32'd0);
    @(negedge Clock);
    check("midrst_pc", {27'd0, Q_Meminst}, 32'd0);

    repeat (5) @(negedge Clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
